// File: rtl/ln_cordic_pkg.sv
// Shared types and constants for the hyperbolic-CORDIC natural-log controller.
//   ctrl_state_e : controller FSM states
//   REP_IDX_A/B  : shift indices issued twice for hyperbolic convergence
//   iter_count() : number of ITER cycles (K) for a given last shift index
package ln_cordic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIter,
    StOut,
    StDone
  } ctrl_state_e;

  localparam int unsigned REP_IDX_A = 4;
  localparam int unsigned REP_IDX_B = 13;

  function automatic int unsigned iter_count(input int unsigned n_iter);
    int unsigned k;
    k = n_iter;
    if (n_iter >= REP_IDX_A) k = k + 1;
    if (n_iter >= REP_IDX_B) k = k + 1;
    return k;
  endfunction

endpackage

// File: rtl/ln_cordic_ctrl_if.sv
// Start/done/acknowledge handshake between the FPU top-level sequencer and the
// CORDIC ln controller.
//   beg_FSM : start request (sequencer -> controller)
//   ack_FSM : result acknowledge (sequencer -> controller)
//   ready   : controller idle and able to accept a start
//   done    : result valid, held until acknowledged
interface ln_cordic_ctrl_if;
  logic beg_FSM;
  logic ack_FSM;
  logic ready;
  logic done;

  modport master (output beg_FSM, output ack_FSM, input ready, input done);
  modport slave  (input beg_FSM, input ack_FSM, output ready, output done);
endinterface

// File: rtl/cordic_idx_counter.sv
// CORDIC shift-index generator with hyperbolic repeat handling.
//   CLK, RST : clock, synchronous active-high reset
//   clr      : reload index to 1 and clear the repeat flag
//   adv      : step to the next issued index
//   idx      : current shift index
//   last     : current index is the final issue (N_ITER with no repeat pending)
module cordic_idx_counter
  import ln_cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 25,
  parameter int unsigned W_IDX  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             adv,
  output logic [W_IDX-1:0] idx,
  output logic             last
);

  logic [W_IDX-1:0] r_idx;
  logic             r_rep;
  logic             w_rep_pt;
  logic             w_rep_pending;

  assign w_rep_pt      = (r_idx == W_IDX'(REP_IDX_A)) || (r_idx == W_IDX'(REP_IDX_B));
  // First issue of a repeat index: the same index must go out once more.
  assign w_rep_pending = w_rep_pt && !r_rep;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      r_idx <= W_IDX'(1);
      r_rep <= 1'b0;
    end else if (adv) begin
      if (w_rep_pending) begin
        r_rep <= 1'b1;
      end else begin
        r_rep <= 1'b0;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign idx  = r_idx;
  assign last = (r_idx == W_IDX'(N_ITER)) && !w_rep_pending;

endmodule

// File: rtl/ln_cordic_ctrl.sv
// Control FSM for the hyperbolic-CORDIC natural-log datapath. Sequences input
// capture, the per-iteration X/Y/Z updates and result capture.
//   CLK, RST  : clock, synchronous active-high reset
//   hs        : start/done/ack handshake with the FPU sequencer
//   ld_init   : EN for the input/initial-value registers
//   sel_init  : 1 = registers load X0/Y0/Z0, 0 = load the CORDIC update
//   ld_iter   : EN for the X/Y/Z iteration registers
//   shift_idx : current CORDIC shift amount (0 outside ITER)
//   ld_out    : EN for the result register
module ln_cordic_ctrl
  import ln_cordic_pkg::*;
#(
  parameter int unsigned N_ITER = 25,
  parameter int unsigned W_IDX  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  ln_cordic_ctrl_if.slave  hs,
  output logic             ld_init,
  output logic             sel_init,
  output logic             ld_iter,
  output logic [W_IDX-1:0] shift_idx,
  output logic             ld_out
);

  ctrl_state_e      r_state;
  logic             r_ready;
  logic             r_done;
  logic             r_ld_init;
  logic             r_sel_init;
  logic             r_ld_iter;
  logic             r_ld_out;
  logic             w_in_iter;
  logic [W_IDX-1:0] w_idx;
  logic             w_last;

  assign w_in_iter = (r_state == StIter);

  // Held cleared outside ITER so the index is 1 on the first ITER cycle.
  cordic_idx_counter #(
    .N_ITER (N_ITER),
    .W_IDX  (W_IDX)
  ) u_idx (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (!w_in_iter),
    .adv  (w_in_iter),
    .idx  (w_idx),
    .last (w_last)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StIdle;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_ld_init  <= 1'b0;
      r_sel_init <= 1'b0;
      r_ld_iter  <= 1'b0;
      r_ld_out   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (hs.beg_FSM) begin
            r_state    <= StLoad;
            r_ready    <= 1'b0;
            r_ld_init  <= 1'b1;
            r_sel_init <= 1'b1;
            r_ld_iter  <= 1'b1;
          end
        end
        StLoad: begin
          r_state    <= StIter;
          r_ld_init  <= 1'b0;
          r_sel_init <= 1'b0;
        end
        StIter: begin
          if (w_last) begin
            r_state   <= StOut;
            r_ld_iter <= 1'b0;
            r_ld_out  <= 1'b1;
          end
        end
        StOut: begin
          r_state  <= StDone;
          r_ld_out <= 1'b0;
          r_done   <= 1'b1;
        end
        StDone: begin
          // beg_FSM is not looked at here: acknowledge always lands in IDLE first.
          if (hs.ack_FSM) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_ready    <= 1'b1;
          r_done     <= 1'b0;
          r_ld_init  <= 1'b0;
          r_sel_init <= 1'b0;
          r_ld_iter  <= 1'b0;
          r_ld_out   <= 1'b0;
        end
      endcase
    end
  end

  assign hs.ready  = r_ready;
  assign hs.done   = r_done;
  assign ld_init   = r_ld_init;
  assign sel_init  = r_sel_init;
  assign ld_iter   = r_ld_iter;
  assign ld_out    = r_ld_out;
  assign shift_idx = w_in_iter ? w_idx : '0;

endmodule
